ringosc_entropy_sampler: RTL and testbench
==========================================

# ringosc_entropy_sampler

Consumer end of the ice40 ring-oscillator chain: samples the free-running, asynchronous oscillator output in the system clock domain and debiases the samples with a von Neumann extractor. Packs the debiased bits into WIDTH-bit random words delivered over a valid/ready handshake. A sticky repetition-count health test blocks output when the oscillator stalls or locks. Sits between a `ringoscillator` instance and any consumer of random words, for example a seed register or a UART dumper.

## Interface
- `WIDTH`, 8: output word width, ≥2.
- `SAMPLE_DIV`, 4: system clocks per raw sample, ≥1; 1 means sample every cycle.
- `REPEAT_LIMIT`, 32: consecutive identical raw samples that trip `fault`, ≥2.
- `clk`  in  1  system clock; sole clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `osc_in`  in  1  asynchronous ring-oscillator output.
- `out_data`  out  WIDTH  random word; stable while `out_valid`.
- `out_valid`  out  1  word available.
- `out_ready`  in  1  consumer accepts; transfer when `out_valid && out_ready` at a rising edge.
- `fault`  out  1  sticky health-test failure.

## Operation
- **Sync:** `osc_in` goes through a two-flop synchronizer. Both flops reset to 0.
- **Sample strobe:** divider counts 0..SAMPLE_DIV-1 and wraps. The strobe is active in the cycle the counter is SAMPLE_DIV-1. On a strobe, the raw sample is the synchronizer output.
- **Health test:** tracks `last_sample` and `have_last`.
  - First strobe after reset: rep_cnt=1.
  - Sample equal to last: rep_cnt+1, saturating at REPEAT_LIMIT.
  - Otherwise: rep_cnt=1.
  - `fault` sets on the edge where rep_cnt becomes REPEAT_LIMIT. It clears only on reset.
- **Von Neumann extractor:** a pair flag toggles on each strobe.
  - On the first strobe of a pair, store sample a.
  - On the second, sample b: if a≠b, emit debiased bit a; if a=b, discard.
  - Pairs never overlap.
- **Collector:** shift register plus bit count 0..WIDTH.
  - Each emitted bit shifts in at bit 0, so the first bit of a word ends in bit WIDTH-1 of `out_data`.
  - At count=WIDTH the collector is full. Further emitted bits are dropped; strobes, pairing and the health test continue.
- **Output register:** the collector transfers to `out_data`/`out_valid` when full and (`!out_valid` or `out_ready`). The transfer clears the collector.
  - An accept without a full collector clears `out_valid`.
- **Fault:** once `fault` is high, `out_valid` drops and the collector clears. Both stay cleared; no further words until reset.
- **Reset:** all state clears regardless of activity: divider, pair flag, rep_cnt, `have_last`, collector, `out_data`=0, `out_valid`=0, `fault`=0. A reset mid-word discards partial bits.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `fault`=0.
- First strobe: cycle SAMPLE_DIV-1 after reset release.
- `osc_in` to synchronizer output: 2 cycles.
- WIDTH-th debiased bit: registered on its strobe edge, collector full that edge. `out_valid` rises the next edge, giving 1 cycle of collector-to-output latency.
- Accept and full collector on the same edge: new word loads, `out_valid` stays high (back-to-back, no bubble).
- Accept edge with no full collector: `out_valid` low next cycle.
- `fault` rises on the edge the REPEAT_LIMIT-th identical sample registers. `out_valid` is low from the following edge, even if a handshake was pending.
- Throughput ceiling: one debiased bit per 2·SAMPLE_DIV cycles.

## Structure
- No shared package needed. All constants are module parameters. Counter widths are derived with `$clog2` as localparams.
- One sub-module: `sync_ff2`, a two-flop synchronizer with synchronous active-low reset. It is reusable for other async inputs.
- Top-level structure: divider, health test, extractor, collector, output register.

## Test plan
Default WIDTH=8, REPEAT_LIMIT=32, SAMPLE_DIV=1 unless noted; stimulus is driven with the 2-cycle sync latency accounted for.
- **Order:** raw pairs 10,01,10,01,01,10,01,10 (debiased bits 1,0,1,0,0,1,0,1) → `out_data`=8'hA5, `out_valid` 1 cycle after the 8th pair.
- **Discard:** 16 raw pairs alternating 00,11 → no `out_valid`, `fault`=0.
- **Stuck input:** `osc_in` held 0 → `fault`=1 on the 32nd strobe. `out_valid` never rises; `fault` holds until `rst_n`=0.
- **Backpressure:** `out_ready`=0 while generating 8'hFF (eight 10 pairs) then 8'h00 (eight 01 pairs) then 8'hFF again → `out_data` stays 8'hFF. The third word is dropped. Raise `out_ready` for 1 cycle → 8'h00 presented the next cycle.
- **Reset mid-word:** 5 debiased 1s, `rst_n` low for 1 cycle, then eight 01 pairs → first word 8'h00. No pre-reset bits appear.
- **SAMPLE_DIV=4:** strobes only every 4th cycle, verified by toggling `osc_in` every cycle → output consistent only with samples taken at those strobes.

Source files
------------

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for one asynchronous bit into the clk domain.
// Both stages clear on synchronous active-low reset.
module sync_ff2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q_out
);

  logic s1_q;
  logic s1_d;
  logic s2_q;
  logic s2_d;

  always_comb begin
    s1_d = d_in;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q_out = s2_q;

endmodule

// File: rtl/ringosc_entropy_sampler.sv
// Samples a free-running ring oscillator, debiases it with a von Neumann extractor
// and packs the bits into WIDTH-bit words behind a sticky repetition-count health test.
module ringosc_entropy_sampler #(
  parameter int WIDTH        = 8,
  parameter int SAMPLE_DIV   = 4,
  parameter int REPEAT_LIMIT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             osc_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             fault
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int REP_W = $clog2(REPEAT_LIMIT + 1);
  localparam int BC_W  = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REPEAT_LIMIT);
  localparam logic [BC_W-1:0]  BC_FULL  = BC_W'(WIDTH);

  logic             sample_s;
  logic             strobe_s;
  logic             bit_vld_s;
  logic             full_s;
  logic             load_s;
  logic [DIV_W-1:0] div_q, div_d;
  logic             last_q, last_d;
  logic             have_last_q, have_last_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             fault_q, fault_d;
  logic             pair_q, pair_d;
  logic             a_q, a_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]  bcnt_q, bcnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  sync_ff2 u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_in (osc_in),
    .q_out(sample_s)
  );

  always_comb begin
    div_d       = div_q;
    last_d      = last_q;
    have_last_d = have_last_q;
    rep_d       = rep_q;
    fault_d     = fault_q;
    pair_d      = pair_q;
    a_d         = a_q;
    bit_vld_s   = 1'b0;
    shreg_d     = shreg_q;
    bcnt_d      = bcnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    strobe_s = (div_q == DIV_LAST);
    if (strobe_s) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (strobe_s) begin
      last_d      = sample_s;
      have_last_d = 1'b1;
      if (have_last_q && (sample_s == last_q)) begin
        if (rep_q != REP_MAX) begin
          rep_d = rep_q + REP_W'(1);
        end else begin
          rep_d = rep_q;
        end
      end else begin
        rep_d = REP_W'(1);
      end
      if (rep_d == REP_MAX) begin
        fault_d = 1'b1;
      end else begin
        fault_d = fault_q;
      end
      // Pairs are disjoint: first strobe stores a, second decides.
      pair_d = ~pair_q;
      if (!pair_q) begin
        a_d = sample_s;
      end else begin
        a_d       = a_q;
        bit_vld_s = (a_q != sample_s);
      end
    end else begin
      pair_d = pair_q;
    end

    full_s = (bcnt_q == BC_FULL);
    load_s = full_s && (!out_valid_q || out_ready) && !fault_q;

    if (fault_q) begin
      shreg_d     = '0;
      bcnt_d      = '0;
      out_valid_d = 1'b0;
    end else if (load_s) begin
      out_data_d  = shreg_q;
      out_valid_d = 1'b1;
      shreg_d     = '0;
      bcnt_d      = '0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
      if (bit_vld_s && !full_s) begin
        shreg_d = {shreg_q[WIDTH-2:0], a_q};
        bcnt_d  = bcnt_q + BC_W'(1);
      end else begin
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q       <= '0;
      last_q      <= 1'b0;
      have_last_q <= 1'b0;
      rep_q       <= '0;
      fault_q     <= 1'b0;
      pair_q      <= 1'b0;
      a_q         <= 1'b0;
      shreg_q     <= '0;
      bcnt_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
      rep_q       <= rep_d;
      fault_q     <= fault_d;
      pair_q      <= pair_d;
      a_q         <= a_d;
      shreg_q     <= shreg_d;
      bcnt_q      <= bcnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_ringosc_entropy_sampler.sv
// Bench: behavioural model of two sampler instances (SAMPLE_DIV=1 and 4),
// compared every cycle, plus hand-computed literal checks.
module tb_ringosc_entropy_sampler;

  localparam int LIMIT = 32;

  logic       clk = 1'b0;
  logic       rst_n, osc_in, out_ready;
  logic [7:0] out_data;
  logic       out_valid, fault;
  logic       rst4_n, osc4;
  logic [7:0] out4_data;
  logic       out4_valid, fault4;

  int total = 0;
  int bad   = 0;

  // Model state per instance: osc seen one and two edges ago, sample history, collected bits.
  logic       mold [2];
  logic       mnew [2];
  int         mn   [2];
  int         mns  [2];
  int         mnb  [2];
  logic       msamp[2][256];
  logic       mbits[2][8];
  logic       mvalid[2];
  logic       mfault[2];
  logic [7:0] mdata[2];

  ringosc_entropy_sampler #(.WIDTH(8), .SAMPLE_DIV(1), .REPEAT_LIMIT(32)) dut (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .fault(fault)
  );

  ringosc_entropy_sampler #(.WIDTH(8), .SAMPLE_DIV(4), .REPEAT_LIMIT(32)) dut4 (
    .clk(clk), .rst_n(rst4_n), .osc_in(osc4), .out_data(out4_data),
    .out_valid(out4_valid), .out_ready(1'b0), .fault(fault4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input int div, input logic rst, input logic osc,
                            input logic rdy);
    logic s, emit, ebit, old_fault, new_fault;
    logic [7:0] w;
    int run;
    if (!rst) begin
      mold[i] = 1'b0; mnew[i] = 1'b0;
      mn[i] = 0; mns[i] = 0; mnb[i] = 0;
      mvalid[i] = 1'b0; mdata[i] = 8'h00; mfault[i] = 1'b0;
    end else begin
      s = mold[i];
      mold[i] = mnew[i];
      mnew[i] = osc;
      emit = 1'b0; ebit = 1'b0; new_fault = 1'b0;
      old_fault = mfault[i];
      if ((mn[i] % div) == div - 1) begin
        msamp[i][mns[i] % 256] = s;
        mns[i]++;
        run = 0;
        for (int k = 0; k < mns[i] && k < LIMIT; k++) begin
          if (msamp[i][(mns[i] - 1 - k) % 256] == s) run++;
          else break;
        end
        if (run >= LIMIT) new_fault = 1'b1;
        if ((mns[i] % 2) == 0 && msamp[i][(mns[i] - 2) % 256] != s) begin
          emit = 1'b1;
          ebit = msamp[i][(mns[i] - 2) % 256];
        end
      end
      mn[i]++;
      if (old_fault) begin
        mvalid[i] = 1'b0;
        mnb[i] = 0;
      end else if (mnb[i] == 8 && (!mvalid[i] || rdy)) begin
        w = 8'h00;
        for (int k = 0; k < 8; k++) w = {w[6:0], mbits[i][k]};
        mdata[i] = w;
        mvalid[i] = 1'b1;
        mnb[i] = 0;
      end else begin
        if (mvalid[i] && rdy) mvalid[i] = 1'b0;
        if (emit && mnb[i] < 8) begin
          mbits[i][mnb[i]] = ebit;
          mnb[i]++;
        end
      end
      if (new_fault) mfault[i] = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 1, rst_n, osc_in, out_ready);
    model_step(1, 4, rst4_n, osc4, 1'b0);
    #1;
    chk("m_valid", {7'd0, out_valid}, {7'd0, mvalid[0]});
    chk("m_fault", {7'd0, fault}, {7'd0, mfault[0]});
    if (mvalid[0]) chk("m_data", out_data, mdata[0]);
    chk("m4_valid", {7'd0, out4_valid}, {7'd0, mvalid[1]});
    chk("m4_fault", {7'd0, fault4}, {7'd0, mfault[1]});
    if (mvalid[1]) chk("m4_data", out4_data, mdata[1]);
  end

  task automatic step(input logic o, input logic r);
    @(negedge clk);
    rst_n = 1'b1; osc_in = o; out_ready = r;
  endtask

  task automatic pair(input logic a, input logic b);
    step(a, 1'b0);
    step(b, 1'b0);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int k = 7; k >= 0; k--) pair(w[k], ~w[k]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; out_ready = 1'b0;
  endtask

  task automatic step4(input logic o);
    @(negedge clk);
    rst4_n = 1'b1; osc4 = o;
  endtask

  function automatic logic f4(input int j);
    logic [31:0] v;
    v = j;
    if (j < 64) return v[0];
    else return v[0] ^ v[2];
  endfunction

  initial begin
    rst_n = 1'b0; osc_in = 1'b0; out_ready = 1'b0;
    rst4_n = 1'b0; osc4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {7'd0, out_valid}, 8'h00);
    chk("rst_data", out_data, 8'h00);
    chk("rst_fault", {7'd0, fault}, 8'h00);
    chk("rst4_valid", {7'd0, out4_valid}, 8'h00);

    // Bit order: A5 appears one cycle after the collector fills.
    send_word(8'hA5);
    pair(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("order_pre_valid", {7'd0, out_valid}, 8'h00);
    step(1'b1, 1'b0);
    chk("order_valid", {7'd0, out_valid}, 8'h01);
    chk("order_data", out_data, 8'hA5);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("accept_empty_valid", {7'd0, out_valid}, 8'h00);

    // Equal pairs are discarded.
    repeat (8) begin
      pair(1'b0, 1'b0);
      pair(1'b1, 1'b1);
    end
    chk("discard_valid", {7'd0, out_valid}, 8'h00);
    chk("discard_fault", {7'd0, fault}, 8'h00);

    // Backpressure: FF held, 00 waits in collector, third FF dropped.
    send_word(8'hFF);
    send_word(8'h00);
    send_word(8'hFF);
    pair(1'b0, 1'b0);
    pair(1'b1, 1'b1);
    chk("bp_valid", {7'd0, out_valid}, 8'h01);
    chk("bp_data", out_data, 8'hFF);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("bp_b2b_valid", {7'd0, out_valid}, 8'h01);
    chk("bp_second_data", out_data, 8'h00);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("bp_third_dropped", {7'd0, out_valid}, 8'h00);

    // Reset mid-word discards partial bits.
    repeat (5) pair(1'b1, 1'b0);
    do_reset();
    step(1'b0, 1'b0);
    chk("midrst_valid", {7'd0, out_valid}, 8'h00);
    chk("midrst_data", out_data, 8'h00);
    step(1'b1, 1'b0);
    repeat (7) pair(1'b0, 1'b1);
    pair(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("midrst_pre_valid", {7'd0, out_valid}, 8'h00);
    step(1'b1, 1'b0);
    chk("midrst_word_valid", {7'd0, out_valid}, 8'h01);
    chk("midrst_word_data", out_data, 8'h00);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Stuck input: fault on the 32nd identical strobe, then sticky.
    do_reset();
    for (int j = 0; j <= 31; j++) step(1'b0, 1'b0);
    chk("stuck_31", {7'd0, fault}, 8'h00);
    step(1'b0, 1'b0);
    chk("stuck_32", {7'd0, fault}, 8'h01);
    repeat (12) pair(1'b1, 1'b0);
    chk("stuck_hold_fault", {7'd0, fault}, 8'h01);
    chk("stuck_no_valid", {7'd0, out_valid}, 8'h00);
    do_reset();
    step(1'b0, 1'b0);
    chk("stuck_cleared", {7'd0, fault}, 8'h00);

    // SAMPLE_DIV=4: toggling every cycle looks constant at the strobes, then a
    // phase pattern yields eight 10 pairs -> FF.
    for (int j = 0; j <= 127; j++) begin
      step4(f4(j));
      if (j == 64) begin
        chk("div4_toggle_valid", {7'd0, out4_valid}, 8'h00);
        chk("div4_toggle_fault", {7'd0, fault4}, 8'h00);
      end
    end
    step4(1'b0);
    chk("div4_pre_valid", {7'd0, out4_valid}, 8'h00);
    step4(1'b0);
    chk("div4_valid", {7'd0, out4_valid}, 8'h01);
    chk("div4_data", out4_data, 8'hFF);
    chk("div4_fault", {7'd0, fault4}, 8'h00);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
